// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions: opcode and function codes plus the scoreboard slot layout
// used by the ID-stage hazard controller.
package hazard_detect_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   localparam int SB_SLOT_W = 7;

   // One in-flight register writer
   typedef struct packed {
      logic       v;
      logic [4:0] wreg;
      logic       ld;
   } sb_slot_t;

   function automatic sb_slot_t sb_empty();
      sb_slot_t s;
      s.v    = 1'b0;
      s.wreg = 5'd0;
      s.ld   = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/hazard_detect_unit_match.sv
// Compares one scoreboard slot against the source registers of the ID instruction.
module hazard_match
   import hazard_detect_unit_pkg::*;
(
   input  sb_slot_t   slot,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   output logic       match
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_uses_rs && (id_rs == slot.wreg);
   assign rt_hit = id_uses_rt && (id_rt == slot.wreg);

   // $0 is hard-wired, so a writer of $0 is never a real producer
   assign match = id_valid && slot.v && (slot.wreg != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard controller: two-slot writer scoreboard, stall/flush priority and a
// saturating stall-cycle counter.
module hazard_detect_unit
   import hazard_detect_unit_pkg::*;
#(
   parameter int FWD   = 1,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_wreg,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_jump,
   input  logic             ex_branch_taken,
   input  logic             stall_ext,
   output logic             bubble,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_cycles
);

   sb_slot_t sb_ex;
   sb_slot_t sb_mem;
   sb_slot_t ex_next;
   logic     ex_match;
   logic     mem_match;
   logic     haz;
   logic     haz_stall;

   hazard_match u_match_ex (
      .slot       (sb_ex),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .match      (ex_match)
   );

   hazard_match u_match_mem (
      .slot       (sb_mem),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .match      (mem_match)
   );

   // With forwarding only a load in EX cannot supply its result in time
   generate
      if (FWD != 0) begin : g_fwd
         assign haz = ex_match && sb_ex.ld;
      end else begin : g_nofwd
         assign haz = ex_match || mem_match;
      end
   endgenerate

   always_comb begin
      bubble     = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      if (Reset) begin
         bubble     = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
      end else if (stall_ext) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         bubble     = 1'b1;
      end else if (haz) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         bubble     = 1'b1;
      end else if (id_jump && id_valid) begin
         ifid_flush = 1'b1;
      end
   end

   assign haz_stall = haz && !stall_ext && !ex_branch_taken;

   always_comb begin
      ex_next      = sb_empty();
      ex_next.v    = id_valid && id_reg_write && !bubble;
      ex_next.wreg = id_wreg;
      ex_next.ld   = id_mem_read;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         sb_ex  <= sb_empty();
         sb_mem <= sb_empty();
      end else if (!stall_ext) begin
         sb_mem <= sb_ex;
         sb_ex  <= ex_next;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         stall_cycles <= '0;
      end else if (haz_stall && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench: a vector table on the forwarding instance plus hand sequences for
// the no-forwarding, external-stall, reset and saturation corners.
module tb_hazard_detect_unit;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_uses_rs = 1'b0;
   logic       id_uses_rt = 1'b0;
   logic [4:0] id_wreg = '0;
   logic       id_reg_write = 1'b0;
   logic       id_mem_read = 1'b0;
   logic       id_jump = 1'b0;
   logic       ex_branch_taken = 1'b0;
   logic       stall_ext = 1'b0;

   logic        b1, pw1, iw1, fl1;
   logic [15:0] cnt1;
   logic        b0, pw0, iw0, fl0;
   logic [15:0] cnt0;
   logic        b2, pw2, iw2, fl2;
   logic [1:0]  cnt2;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   hazard_detect_unit #(.FWD(1), .CNT_W(16)) d1 (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext), .bubble(b1),
      .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .stall_cycles(cnt1));

   hazard_detect_unit #(.FWD(0), .CNT_W(16)) d0 (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext), .bubble(b0),
      .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0), .stall_cycles(cnt0));

   hazard_detect_unit #(.FWD(1), .CNT_W(2)) d2 (
      .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext), .bubble(b2),
      .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2), .stall_cycles(cnt2));

   typedef struct {
      logic       valid;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] wreg;
      logic       rw, mr, jmp, br;
      logic [3:0] exp_ctl;   // {bubble, pc_write, ifid_write, ifid_flush}
      int         exp_cnt;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs,
                               logic urt, logic [4:0] wr, logic rw, logic mr,
                               logic jmp, logic br, logic [3:0] ctl, int cnt);
      vec_t t;
      t.valid = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.wreg = wr;
      t.rw = rw; t.mr = mr; t.jmp = jmp; t.br = br; t.exp_ctl = ctl; t.exp_cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic jmp);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_wreg = wr; id_reg_write = rw; id_mem_read = mr; id_jump = jmp;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      ex_branch_taken = 1'b0;
      stall_ext = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      #1;
   endtask

   initial begin
      tbl[0]  = mk(1, 5'd1,  5'd0,  1, 0, 5'd8,  1, 1, 0, 0, 4'b0110, 0); // lw $8
      tbl[1]  = mk(1, 5'd8,  5'd8,  1, 1, 5'd9,  1, 0, 0, 0, 4'b1000, 0); // add $9,$8,$8 stall
      tbl[2]  = mk(1, 5'd8,  5'd8,  1, 1, 5'd9,  1, 0, 0, 0, 4'b0110, 1); // add issues
      tbl[3]  = mk(1, 5'd9,  5'd9,  1, 1, 5'd10, 1, 0, 0, 0, 4'b0110, 1); // ALU dep, forwarded
      tbl[4]  = mk(1, 5'd0,  5'd0,  0, 0, 5'd0,  0, 0, 1, 0, 4'b0111, 1); // j
      tbl[5]  = mk(1, 5'd2,  5'd0,  1, 0, 5'd0,  1, 1, 0, 0, 4'b0110, 1); // lw $0
      tbl[6]  = mk(1, 5'd0,  5'd0,  1, 1, 5'd11, 1, 0, 0, 0, 4'b0110, 1); // reader of $0
      tbl[7]  = mk(1, 5'd3,  5'd0,  1, 0, 5'd12, 1, 1, 0, 0, 4'b0110, 1); // lw $12
      tbl[8]  = mk(1, 5'd12, 5'd0,  1, 0, 5'd13, 1, 0, 0, 1, 4'b1111, 1); // dep + branch taken
      tbl[9]  = mk(1, 5'd12, 5'd0,  1, 0, 5'd13, 1, 0, 0, 0, 4'b0110, 1); // MEM load, forwarded
      tbl[10] = mk(0, 5'd13, 5'd13, 1, 1, 5'd14, 1, 0, 0, 0, 4'b0110, 1); // invalid ID

      // Reset values while asserted
      #2;
      chk("reset_ctl", {b1, pw1, iw1, fl1}, 4'b1001);
      chk("reset_cnt", cnt1, 0);
      do_reset();

      foreach (tbl[i]) begin
         drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
               tbl[i].wreg, tbl[i].rw, tbl[i].mr, tbl[i].jmp);
         ex_branch_taken = tbl[i].br;
         #1;
         chk($sformatf("tbl%0d_ctl", i), {b1, pw1, iw1, fl1}, tbl[i].exp_ctl);
         chk($sformatf("tbl%0d_cnt", i), cnt1, tbl[i].exp_cnt);
         tick();
      end
      ex_branch_taken = 1'b0;

      // No forwarding: dependency on the instruction directly ahead
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 0, 0);               // addi $5
      chk("nf_adj_first", b0, 0);
      tick();
      drive(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0, 0);               // sub $6,$5,$0
      chk("nf_adj_s1", {b0, pw0}, 2'b10);
      tick();
      chk("nf_adj_s2", {b0, pw0}, 2'b10);
      tick();
      chk("nf_adj_go", {b0, pw0}, 2'b01);
      chk("nf_adj_cnt", cnt0, 2);

      // No forwarding: one independent instruction between
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 0, 0);
      tick();
      drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);               // or $7,$1,$2
      chk("nf_gap_mid", b0, 0);
      tick();
      drive(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0, 0);
      chk("nf_gap_s1", {b0, pw0}, 2'b10);
      tick();
      chk("nf_gap_go", {b0, pw0}, 2'b01);
      chk("nf_gap_cnt", cnt0, 1);

      // Load-use with external stall held for 3 cycles at the stall cycle
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      tick();
      drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
      chk("sx_pre", {b1, pw1, iw1, fl1}, 4'b1000);
      stall_ext = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("sx_frz%0d", k), {b1, pw1, iw1, fl1}, 4'b0000);
         tick();
      end
      stall_ext = 1'b0;
      #1;
      chk("sx_bubble", {b1, pw1, iw1, fl1}, 4'b1000);
      tick();
      chk("sx_go", {b1, pw1, iw1, fl1}, 4'b0110);
      chk("sx_cnt", cnt1, 1);

      // Reset pulsed in the middle of a load-use stall
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0);
      tick();
      drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
      chk("rs_stall", b1, 1);
      Reset = 1'b1;
      #1;
      chk("rs_held", {b1, pw1, iw1, fl1}, 4'b1001);
      tick();
      Reset = 1'b0;
      #1;
      chk("rs_release", {b1, pw1}, 2'b01);
      chk("rs_cnt", cnt1, 0);

      // Saturation: 5 load-use stalls on a 2-bit counter
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0);
         tick();
         drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
         tick();
         tick();
      end
      chk("sat_cnt2", cnt2, 3);
      chk("sat_cnt16", cnt1, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
